alu_issue_sequencer: RTL and testbench



---
 rtl/alu_issue_sequencer.sv | 108 ++++++++++
 tb/tb_alu_issue_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: issues one ALU op to the r0 multiplexer, ignores stale ready, times out, holds the result until consumed
module alu_issue_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       req_ready,
  output logic       mux_en,
  output logic [1:0] mux_state,
  output logic [7:0] mux_value1,
  output logic [7:0] mux_value2,
  input  logic       mux_ready,
  input  logic [7:0] mux_out1,
  input  logic [7:0] mux_out2,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_lo,
  output logic [7:0] res_hi,
  output logic [1:0] res_op,
  output logic       res_timeout,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_state;
  logic [7:0] r_cnt, w_cnt;
  logic [1:0] r_op, w_op, r_res_op, w_res_op;
  logic [7:0] r_a, w_a, r_b, w_b, r_lo, w_lo, r_hi, w_hi;
  logic r_to, w_to, r_req_ready, r_en, r_valid, r_busy;
  logic w_accept, w_fin, w_expire;
  assign w_accept = r_state == IDLE && req_valid && r_req_ready;
  // ready in the first RUN cycle may be left over from the previous op
  assign w_fin    = r_state == RUN && mux_ready && r_cnt != 8'd0;
  assign w_expire = r_state == RUN && r_cnt == 8'(TIMEOUT - 1);
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_op     = r_op;
    w_a      = r_a;
    w_b      = r_b;
    w_lo     = r_lo;
    w_hi     = r_hi;
    w_to     = r_to;
    w_res_op = r_res_op;
    if (w_accept) begin
      w_state = RUN;
      w_cnt   = 8'd0;
      w_op    = req_op;
      w_a     = req_a;
      w_b     = req_b;
    end else if (w_fin || w_expire) begin
      w_state  = DONE;
      w_lo     = w_fin ? mux_out1 : 8'h00;
      w_hi     = (w_fin && r_op == 2'd2) ? mux_out2 : 8'h00;
      w_to     = !w_fin;
      w_res_op = r_op;
    end else if (r_state == RUN) begin
      w_cnt = (r_cnt == 8'(TIMEOUT)) ? r_cnt : r_cnt + 8'd1;
    end else if (r_state == DONE && res_ready) begin
      w_state = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_op        <= 2'd0;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_lo        <= 8'd0;
      r_hi        <= 8'd0;
      r_to        <= 1'b0;
      r_res_op    <= 2'd0;
      r_req_ready <= 1'b0;
      r_en        <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_op        <= w_op;
      r_a         <= w_a;
      r_b         <= w_b;
      r_lo        <= w_lo;
      r_hi        <= w_hi;
      r_to        <= w_to;
      r_res_op    <= w_res_op;
      r_req_ready <= w_state == IDLE;
      r_en        <= w_state == RUN;
      r_valid     <= w_state == DONE;
      r_busy      <= w_state != IDLE;
    end
  end
  assign req_ready   = r_req_ready;
  assign mux_en      = r_en;
  assign mux_state   = r_op;
  assign mux_value1  = r_a;
  assign mux_value2  = r_b;
  assign res_valid   = r_valid;
  assign res_lo      = r_lo;
  assign res_hi      = r_hi;
  assign res_op      = r_res_op;
  assign res_timeout = r_to;
  assign busy        = r_busy;
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer: directed checks against a 3-cycle multiplexer model
module tb_alu_issue_sequencer;
  logic clk = 0, reset = 1, req_valid = 0, res_ready = 0;
  logic [1:0] req_op = 0;
  logic [7:0] req_a = 0, req_b = 0;
  logic req_ready, mux_en, mux_ready, res_valid, res_timeout, busy;
  logic [1:0] mux_state, res_op;
  logic [7:0] mux_value1, mux_value2, mux_out1, mux_out2, res_lo, res_hi;
  logic m_rdy, force_rdy = 0, never = 0;
  logic [7:0] m_o1, m_o2;
  int m_cnt;
  int n_cmp = 0, n_err = 0;
  alu_issue_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mux_en(mux_en), .mux_state(mux_state), .mux_value1(mux_value1),
    .mux_value2(mux_value2), .mux_ready(mux_ready), .mux_out1(mux_out1), .mux_out2(mux_out2),
    .res_valid(res_valid), .res_ready(res_ready), .res_lo(res_lo), .res_hi(res_hi), .res_op(res_op),
    .res_timeout(res_timeout), .busy(busy)
  );
  always #5 clk = ~clk;
  assign mux_ready = m_rdy | force_rdy;
  assign mux_out1  = force_rdy ? 8'hAA : m_o1;
  assign mux_out2  = force_rdy ? 8'hBB : m_o2;
  function automatic logic [15:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = op == 2'd0 ? a + b : op == 2'd1 ? a - b : 8'h00 - a;
    return op == 2'd2 ? 16'(a) * 16'(b) : {8'h5A, s};
  endfunction
  always_ff @(posedge clk) begin
    if (!mux_en) begin
      m_cnt <= 0;
      m_rdy <= 1'b0;
    end else if (m_cnt == 2) begin
      if (!never) begin
        m_rdy <= 1'b1;
        {m_o2, m_o1} <= alu(mux_state, mux_value1, mux_value2);
      end
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int i;
    i = 0;
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    while (!req_ready && i < 50) begin tick(); i++; end
    chk("issue_ready", 32'(req_ready), 1);
    tick();
    req_valid = 0;
    chk("issue_en", 32'(mux_en), 1);
  endtask
  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
  endtask
  task automatic consume();
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("consume_valid", 32'(res_valid), 0);
    chk("consume_req_ready", 32'(req_ready), 1);
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, 32'({req_ready, mux_en, mux_state, mux_value1, mux_value2, res_valid, busy}), 0);
    chk({tag, "_res"}, 32'({res_lo, res_hi, res_op, res_timeout}), 0);
  endtask
  initial begin
    int n;
    logic hit;
    tick(); tick();
    chk_reset_outs("rst");
    reset = 0;
    tick();
    chk("rst_release_ready", 32'(req_ready), 1);
    force_rdy = 1;
    tick(); tick();
    force_rdy = 0;
    chk("idle_ready_ignored", 32'({res_valid, busy}), 0);
    issue(2'd0, 8'd100, 8'd27);
    chk("add_operands", 32'({mux_state, mux_value1, mux_value2}), {2'd0, 8'd100, 8'd27});
    chk("add_busy_noreq", 32'({busy, req_ready}), 2'b10);
    wait_res(n);
    chk("add_latency", n, 4);
    chk("add_lo", 32'(res_lo), 127);
    chk("add_hi", 32'(res_hi), 0);
    chk("add_op_to", 32'({res_op, res_timeout}), 0);
    consume();
    issue(2'd2, 8'd20, 8'd13);
    wait_res(n);
    chk("mul_latency", n, 4);
    chk("mul_result", 32'({res_hi, res_lo}), 16'h0104);
    chk("mul_op_to", 32'({res_op, res_timeout}), {2'd2, 1'b0});
    consume();
    force_rdy = 1;
    issue(2'd1, 8'd5, 8'd9);
    tick();
    force_rdy = 0;
    chk("stale_ignored", 32'(res_valid), 0);
    wait_res(n);
    chk("sub_latency", n, 3);
    chk("sub_result", 32'({res_hi, res_lo}), 16'h00FC);
    chk("sub_op", 32'(res_op), 1);
    consume();
    issue(2'd0, 8'd1, 8'd2);
    wait_res(n);
    req_valid = 1; req_op = 2'd3; req_a = 8'd7; req_b = 8'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", 32'({res_valid, req_ready, mux_en, res_hi, res_lo}), {3'b100, 16'h0003});
    end
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("bp_consumed", 32'({res_valid, req_ready, mux_en}), 3'b010);
    tick();
    req_valid = 0;
    chk("bp_accept", 32'({mux_en, mux_state, mux_value1}), {1'b1, 2'd3, 8'd7});
    wait_res(n);
    chk("bp_neg7", 32'({res_hi, res_lo}), 16'h00F9);
    consume();
    never = 1;
    issue(2'd0, 8'd1, 8'd1);
    wait_res(n);
    never = 0;
    chk("to_latency", n, 8);
    chk("to_flag", 32'(res_timeout), 1);
    chk("to_zero", 32'({res_hi, res_lo}), 0);
    consume();
    issue(2'd3, 8'd1, 8'd0);
    wait_res(n);
    chk("neg1_result", 32'({res_hi, res_lo, res_timeout}), {16'h00FF, 1'b0});
    consume();
    issue(2'd2, 8'd3, 8'd4);
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk_reset_outs("midrun_rst");
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      hit = hit | res_valid;
    end
    chk("abort_no_valid", 32'(hit), 0);
    issue(2'd2, 8'd3, 8'd4);
    wait_res(n);
    chk("post_rst_mul", 32'({res_hi, res_lo, res_timeout}), {16'h000C, 1'b0});
    consume();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
